// File: rtl/calc_pkg.sv
// calc_pkg: opcodes, scheduler states, error result and keypad codes shared by the calculator datapath
package calc_pkg;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_DIV = 3'd2, OP_MUL = 3'd3, OP_POW = 3'd4, OP_PCT = 3'd5;
  localparam logic [7:0] ERR_RESULT = 8'hFF;
  localparam logic [3:0] KEY_ADD = 4'hA, KEY_SUB = 4'hB, KEY_MUL = 4'hC, KEY_DIV = 4'hD, KEY_EQ = 4'hE, KEY_CLR = 4'hF;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  function automatic logic op_illegal(input logic [2:0] op, input logic b_zero);
    return op[2:1] == 2'b11 || (op == OP_DIV && b_zero);
  endfunction
endpackage

// File: rtl/alu_scheduler_if.sv
// alu_scheduler_if: requester, response, execution-unit and status signals of the ALU scheduler
interface alu_scheduler_if #(parameter int WIDTH_IN = 4, parameter int WIDTH_OUT = 8);
  logic [1:0] req_valid, req_ready;
  logic [2*WIDTH_IN-1:0] req_a, req_b;
  logic [5:0] req_op;
  logic [1:0] rsp_valid, rsp_ready;
  logic [WIDTH_OUT-1:0] rsp_data;
  logic rsp_err;
  logic exe_start;
  logic [WIDTH_IN-1:0] exe_a, exe_b;
  logic [2:0] exe_op;
  logic exe_done;
  logic [WIDTH_OUT-1:0] exe_result;
  logic busy;
  logic [7:0] err_count;
  modport slave (
    input req_valid, req_a, req_b, req_op, rsp_ready, exe_done, exe_result,
    output req_ready, rsp_valid, rsp_data, rsp_err, exe_start, exe_a, exe_b, exe_op, busy, err_count
  );
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, exe_done, exe_result,
    input req_ready, rsp_valid, rsp_data, rsp_err, exe_start, exe_a, exe_b, exe_op, busy, err_count
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the caller owns and updates the pointer
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);
  assign grant_o = &req_i ? (ptr_i ? 2'b10 : 2'b01) : req_i;
endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: arbitrates two requesters onto the shared execution unit, screens illegal ops, times out stuck runs
module alu_scheduler
  import calc_pkg::*;
#(
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 8,
  parameter int TIMEOUT   = 64
) (
  input logic clk,
  input logic reset,
  alu_scheduler_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_e state_q;
  logic ptr_q, id_q, err_q, start_q, g, bad, timeout;
  logic [1:0] grant, rsp_valid_q;
  logic [WIDTH_IN-1:0] a_q, b_q, a_sel, b_sel;
  logic [2:0] op_q, op_sel;
  logic [WIDTH_OUT-1:0] data_q;
  logic [CW-1:0] cnt_q;
  logic [7:0] err_cnt_q, err_cnt_d;
  rr_arbiter2 u_arb (.req_i(bus.req_valid), .ptr_i(ptr_q), .grant_o(grant));
  assign g = grant[1];
  assign a_sel = g ? bus.req_a[2*WIDTH_IN-1 -: WIDTH_IN] : bus.req_a[WIDTH_IN-1:0];
  assign b_sel = g ? bus.req_b[2*WIDTH_IN-1 -: WIDTH_IN] : bus.req_b[WIDTH_IN-1:0];
  assign op_sel = g ? bus.req_op[5:3] : bus.req_op[2:0];
  assign bad = op_illegal(op_sel, b_sel == '0);
  // counter is 0 in the first WAIT cycle, so the abort lands TIMEOUT cycles after ISSUE
  assign timeout = cnt_q == CW'(TIMEOUT - 2);
  assign err_cnt_d = &err_cnt_q ? err_cnt_q : err_cnt_q + 8'd1;
  assign bus.req_ready = reset && state_q == IDLE ? grant : 2'b00;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data = data_q;
  assign bus.rsp_err = err_q;
  assign bus.exe_start = start_q;
  assign bus.exe_a = a_q;
  assign bus.exe_b = b_q;
  assign bus.exe_op = op_q;
  assign bus.busy = state_q != IDLE;
  assign bus.err_count = err_cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      id_q <= 1'b0;
      err_q <= 1'b0;
      start_q <= 1'b0;
      rsp_valid_q <= 2'b00;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      err_cnt_q <= '0;
    end else
      case (state_q)
        IDLE: if (|grant) begin
          a_q <= a_sel;
          b_q <= b_sel;
          op_q <= op_sel;
          id_q <= g;
          ptr_q <= ~g;
          if (bad) begin
            state_q <= RESP;
            rsp_valid_q <= grant;
            data_q <= WIDTH_OUT'(ERR_RESULT);
            err_q <= 1'b1;
            err_cnt_q <= err_cnt_d;
          end else begin
            state_q <= ISSUE;
            start_q <= 1'b1;
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
          cnt_q <= '0;
          state_q <= WAIT;
        end
        WAIT: if (bus.exe_done) begin
          data_q <= bus.exe_result;
          err_q <= 1'b0;
          rsp_valid_q <= {id_q, ~id_q};
          state_q <= RESP;
        end else if (timeout) begin
          data_q <= WIDTH_OUT'(ERR_RESULT);
          err_q <= 1'b1;
          err_cnt_q <= err_cnt_d;
          rsp_valid_q <= {id_q, ~id_q};
          state_q <= RESP;
        end else cnt_q <= cnt_q + 1'b1;
        RESP: if (bus.rsp_ready[id_q]) begin
          rsp_valid_q <= 2'b00;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequencing and arbitration front-end for the calculator's shared ALU/power execution unit. Two requesters (port 0: keypad controller, port 1: auxiliary engine) submit operand/opcode pairs over valid/ready. The block round-robins between them, pre-screens illegal operations, issues one start pulse to the multi-cycle execution unit, waits for its done strobe with a timeout, and returns the result to the winning requester.

## Interface
- `WIDTH_IN`, 4: operand width.
- `WIDTH_OUT`, 8: result width.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before the request is aborted; must be ≥2.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `req_valid` input 2: per-requester request valid.
- `req_ready` output 2: per-requester accept, combinational.
- `req_a`, `req_b` input 2×WIDTH_IN: packed operands, requester i at slice i.
- `req_op` input 2×3: packed opcodes.
- `rsp_valid` output 2: response valid to the owning requester.
- `rsp_ready` input 2: response accept.
- `rsp_data` output WIDTH_OUT: shared result bus.
- `rsp_err` output 1: response is an error.
- `exe_start` output 1: one-cycle launch pulse.
- `exe_a`, `exe_b` output WIDTH_IN: latched operands.
- `exe_op` output 3: latched opcode.
- `exe_done` input 1: unit completion strobe.
- `exe_result` input WIDTH_OUT: valid when `exe_done`=1.
- `busy` output 1: state ≠ IDLE.
- `err_count` output 8: saturating error counter.

## Operation
- Opcodes: 000 add, 001 sub, 010 div, 011 mul, 100 pow, 101 pct. 110 and 111 are illegal.
- States:
  - IDLE: `req_ready[g]`=1 only for granted g.
  - ISSUE: `exe_start`=1.
  - WAIT.
  - RESP: `rsp_valid[id]`=1.
- Arbitration in IDLE:
  - If one requester is valid, it is granted.
  - If both are valid, grant goes to the requester the priority pointer favors.
  - On each accept, the pointer moves to favor the other requester.
  - The pointer resets to favor requester 0.
- Accept (IDLE with `req_valid[g]`=1):
  - Latch a, b, op and id=g.
  - If the op is illegal, or op=010 with b=0: go to RESP with `rsp_data`=8'hFF and `rsp_err`=1. The unit is never started.
  - Otherwise go to ISSUE.
- ISSUE → WAIT unconditionally. The timeout counter clears.
- WAIT:
  - On `exe_done`=1: latch `exe_result` and set err=0, then go to RESP.
  - Otherwise, when the counter reaches TIMEOUT−1: set `rsp_data`=8'hFF and err=1, then go to RESP.
  - If `exe_done` and the timeout occur in the same cycle, done wins.
- RESP:
  - `rsp_valid[id]`, `rsp_data` and `rsp_err` are held stable until `rsp_ready[id]`=1.
  - Then go to IDLE. `rsp_ready` of the non-owner is ignored.
- `exe_done` outside WAIT is ignored. This includes `exe_done` in the ISSUE cycle.
- `err_count` increments by 1 in the cycle each error response enters RESP, and saturates at 255.
- `exe_a`, `exe_b` and `exe_op` hold their latched values from accept until the next accept.

## Timing
- Reset values:
  - State IDLE; `exe_start`=0.
  - `rsp_valid`=00, `rsp_data`=0, `rsp_err`=0.
  - `exe_a`=0, `exe_b`=0, `exe_op`=0.
  - `busy`=0, `err_count`=0.
  - Pointer favors requester 0.
  - `req_ready`=00 while reset is asserted.
- Reset mid-transaction aborts it: no response, and no further `exe_start`.
- Legal-op latency:
  - Accept edge at cycle 0.
  - `exe_start` high during cycle 1.
  - Earliest `exe_done` is sampled in cycle 2.
  - `rsp_valid` rises in cycle 3.
- Error-path latency: `rsp_valid` is high in the cycle after accept.
- Throughput:
  - One request is outstanding at a time.
  - The next accept is possible in the cycle after the response handshake.
  - Best case is one request per 4 cycles.
- The timeout response appears TIMEOUT cycles after the ISSUE cycle.

## Structure
- Package `calc_pkg` holds:
  - Opcode localparams OP_ADD..OP_PCT.
  - State encoding.
  - ERR_RESULT = 8'hFF.
  - Keypad key codes, including KEY_EQ = 4'hE.
- Sub-module `rr_arbiter2` is combinational:
  - Inputs: req[1:0], pointer.
  - Outputs: one-hot grant.
  - The pointer update lives in `alu_scheduler`.

## Test plan
- **Single requester add:** req0 a=3, b=4, op=000; unit model done at 2 cycles with result 7. Required: one `exe_start` pulse, `rsp_valid`=01, `rsp_data`=7, `rsp_err`=0, and the response appears 3 cycles after accept when done is sampled in cycle 2.
- **Contention:** both requesters valid continuously. Required grants alternate 0,1,0,1 over 4 transactions, and each `rsp_valid` bit matches the granted requester.
- **Screening:** div with b=0 and op=110 each give `rsp_data`=FF and `rsp_err`=1 in the cycle after accept, with no `exe_start`; `err_count`=2 afterwards.
- **Timeout:** TIMEOUT=8 with a unit that never asserts done. Required: `rsp_data`=FF, `rsp_err`=1, response 8 cycles after ISSUE. A late `exe_done` is ignored.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles on a pow 2^3=8 response. Required: `rsp_valid`, `rsp_data`=8 and `rsp_err`=0 are stable throughout, `req_ready`=00 throughout, and the next accept is possible in the cycle after the handshake.
- **Reset mid-WAIT:** assert reset during WAIT. Required: all outputs at reset values immediately, no response, and the first request after reset is served normally.
